ram_cmd_sequencer: RTL and testbench

// - Upstream driver for the asynchronous 32x32 RAM (ports address/writeOn/data_in/data_out).
// - Accepts packed command words over valid/ready, buffers them in a small FIFO, sequences each

---
 rtl/ram_pkg.sv | 33 +++
 rtl/ram_cmd_fifo.sv | 72 +++++++
 rtl/ram_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_ram_cmd_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared widths, command layout and sequencer states for the RAM command path
package ram_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int CMD_W    = 38;
  localparam int ADDR_LSB = 33;
  localparam int WR_BIT   = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } seq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // Split a packed command word into its address / write flag / data fields
  function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] word);
    cmd_t c;
    c.addr = word[ADDR_LSB +: ADDR_W];
    c.wr   = word[WR_BIT];
    c.data = word[DATA_W-1:0];
    return c;
  endfunction

endpackage

// File: rtl/ram_cmd_fifo.sv
// rtl/ram_cmd_fifo.sv - synchronous command FIFO with registered full/empty flags
module ram_cmd_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  // Flags are registered, so a push while full is refused even if a pop frees a slot this cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head entry is read straight from storage so the consumer can latch it on the pop edge
  assign dout = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage write; contents need no reset because empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer, count and flag registers; pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/ram_cmd_sequencer.sv
// rtl/ram_cmd_sequencer.sv - buffers command words and sequences glitch-safe accesses to the async RAM
module ram_cmd_sequencer
  import ram_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_word,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_writeOn,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_address,
  output logic              busy,
  output logic [7:0]        done_count
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_head;
  cmd_t             head;
  logic             cur_wr;
  logic [SET_W-1:0] settle_cnt;
  logic             settle_done;

  ram_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .din   (cmd_word),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head        = unpack_cmd(fifo_head);
  assign settle_done = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));

  // Both derived only from registers, so nothing combinational reaches them from the inputs
  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  // Next-state logic and FIFO pop request
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (settle_done) begin
          state_nxt = cur_wr ? STROBE : RESP;
        end
      end
      STROBE:  state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RAM-side registers: address/data only move on the IDLE->SETUP edge; strobe is one cycle wide
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_address <= '0;
      ram_data_in <= '0;
      cur_wr      <= 1'b0;
      ram_writeOn <= 1'b0;
    end else begin
      if (state == IDLE && fifo_pop) begin
        ram_address <= head.addr;
        ram_data_in <= head.data;
        cur_wr      <= head.wr;
      end
      ram_writeOn <= (state_nxt == STROBE);
    end
  end

  // Settle counter: restarts on each new command, advances while in SETUP
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (state == IDLE) begin
      settle_cnt <= '0;
    end else if (state == SETUP && !settle_done) begin
      settle_cnt <= settle_cnt + SET_W'(1);
    end
  end

  // Response registers: capture the read at the end of SETUP, hold until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_address <= '0;
    end else if (state == SETUP && settle_done && !cur_wr) begin
      rsp_valid   <= 1'b1;
      rsp_data    <= ram_data_out;
      rsp_address <= ram_address;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completion counter: writes complete leaving HOLD, reads on the response handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      done_count <= '0;
    end else if (state == HOLD || (state == RESP && rsp_ready)) begin
      done_count <= done_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ram_cmd_sequencer.sv
// tb/tb_ram_cmd_sequencer.sv - self-checking bench for ram_cmd_sequencer with a behavioural RAM
module tb_ram_cmd_sequencer;
  import ram_pkg::*;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [37:0] cmd_word;
  logic [4:0]  ram_address;
  logic        ram_writeOn;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_address;
  logic        busy;
  logic [7:0]  done_count;

  ram_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_word     (cmd_word),
    .ram_address  (ram_address),
    .ram_writeOn  (ram_writeOn),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_address  (rsp_address),
    .busy         (busy),
    .done_count   (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 32x32 RAM: combinational read, writes while writeOn is high
  logic [31:0] ram_mem [32];
  logic        ram_clear;
  assign ram_data_out = ram_mem[ram_address];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= 32'h0;
    end else if (ram_writeOn) begin
      ram_mem[ram_address] <= ram_data_in;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference model: in-order command list, RAM image and completion count
  typedef struct {
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_model [32];
  logic [7:0]  exp_done;
  logic        chk_en;
  logic        p_we, p_rv, p_rr;
  logic [4:0]  p_addr, p_raddr;
  logic [31:0] p_data, p_rdata;
  int          we_len;

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    int   inc;
    exp_t e;
    inc = 0;
    if (ram_clear) begin
      for (int i = 0; i < 32; i++) mem_model[i] = 32'h0;
    end
    if (!chk_en) begin
      exp_q.delete();
      exp_done = 8'd0;
      we_len   = 0;
    end else begin
      chk("done_count", done_count, exp_done);
      if (ram_writeOn && !p_we) begin
        chk("addr_before_strobe", ram_address, p_addr);
        chk("data_before_strobe", ram_data_in, p_data);
        we_len = 1;
        if (exp_q.size() == 0) begin
          fail_now("strobe_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("strobe_is_write", 1, e.wr);
          chk("strobe_addr", ram_address, e.addr);
          chk("strobe_data", ram_data_in, e.data);
          mem_model[e.addr] = e.data;
        end
      end else if (ram_writeOn) begin
        we_len++;
      end
      if (!ram_writeOn && p_we) begin
        chk("addr_after_strobe", ram_address, p_addr);
        chk("data_after_strobe", ram_data_in, p_data);
        chk("strobe_width", we_len, 1);
        inc++;
      end
      if (rsp_valid) chk("we_during_resp", ram_writeOn, 0);
      if (rsp_valid && !p_rv) begin
        if (exp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_is_read", 0, e.wr);
          chk("rsp_address", rsp_address, e.addr);
          chk("rsp_data", rsp_data, mem_model[e.addr]);
        end
      end
      if (rsp_valid && p_rv && !p_rr) begin
        chk("rsp_data_stable", rsp_data, p_rdata);
        chk("rsp_addr_stable", rsp_address, p_raddr);
      end
      if (rsp_valid && rsp_ready) inc++;
      if (cmd_valid && cmd_ready) begin
        e.addr = cmd_word[37:33];
        e.wr   = cmd_word[32];
        e.data = cmd_word[31:0];
        exp_q.push_back(e);
      end
      exp_done = exp_done + 8'(inc);
    end
    p_we    = ram_writeOn;
    p_rv    = rsp_valid;
    p_rr    = rsp_ready;
    p_addr  = ram_address;
    p_data  = ram_data_in;
    p_raddr = rsp_address;
    p_rdata = rsp_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic wr, input logic [31:0] d);
    bit ok;
    ok = 0;
    cmd_word  = {a, wr, d};
    cmd_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (cmd_ready) begin
        step();
        ok = 1;
        break;
      end
      step();
    end
    cmd_valid = 1'b0;
    if (!ok) fail_now("push_timeout");
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      if (!busy && !rsp_valid) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] exp_d, input string tag);
    bit ok;
    ok = 0;
    push(a, 1'b0, 32'h0);
    for (int n = 0; n < 60; n++) begin
      if (rsp_valid) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) fail_now({tag, "_rsp_timeout"});
    else begin
      chk({tag, "_data"}, rsp_data, exp_d);
      chk({tag, "_addr"}, rsp_address, a);
    end
  endtask

  initial begin
    logic [7:0] d0;
    bit         ok;
    reset     = 1'b1;
    chk_en    = 1'b0;
    ram_clear = 1'b1;
    cmd_valid = 1'b0;
    cmd_word  = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_writeOn", ram_writeOn, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_count, 0);
    chk("rst_address", ram_address, 0);
    ram_clear = 1'b0;
    reset     = 1'b0;
    step();
    chk_en = 1'b1;
    step();

    // Write latency: strobe in cycle 3 after the accept edge
    cmd_word  = {5'd3, 1'b1, 32'hDEADBEEF};
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    d0 = done_count;
    step();
    chk("wr_c2_writeOn", ram_writeOn, 0);
    step();
    chk("wr_c3_writeOn", ram_writeOn, 1);
    chk("wr_c3_addr", ram_address, 3);
    chk("wr_c3_data", ram_data_in, 32'hDEADBEEF);
    step();
    chk("wr_c4_writeOn", ram_writeOn, 0);
    step();
    chk("wr_done", done_count, 1);

    // Read latency: rsp_valid in cycle 3
    cmd_word  = {5'd3, 1'b0, 32'h0};
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rd_c2_valid", rsp_valid, 0);
    step();
    chk("rd_c3_valid", rsp_valid, 1);
    chk("rd_c3_data", rsp_data, 32'hDEADBEEF);
    chk("rd_c3_addr", rsp_address, 3);
    step();
    chk("rd_done", done_count, 2);
    chk("rd_valid_cleared", rsp_valid, 0);
    chk("first_done_delta", done_count - d0, 2);

    // Response stall with a full FIFO behind it
    push(5'd7, 1'b1, 32'hA5A50007);
    wait_idle(40);
    rsp_ready = 1'b0;
    do_read(5'd7, 32'hA5A50007, "stall_rd");
    for (int i = 0; i < 4; i++) push(5'(10 + i), 1'b1, 32'h1000 + 32'(10 + i));
    chk("full_cmd_ready", cmd_ready, 0);
    cmd_word  = {5'd14, 1'b1, 32'h100E};
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stall_writeOn", ram_writeOn, 0);
    end
    chk("stall_cmd_ready", cmd_ready, 0);
    chk("stall_valid", rsp_valid, 1);
    chk("stall_data", rsp_data, 32'hA5A50007);
    chk("stall_addr", rsp_address, 7);
    rsp_ready = 1'b1;
    push(5'd14, 1'b1, 32'h100E);
    wait_idle(80);
    chk("stall_done", done_count, 9);
    do_read(5'd12, 32'h100C, "fifo_rd");
    wait_idle(40);

    // Reset while the strobe is high
    push(5'd9, 1'b1, 32'hCAFEF00D);
    ok = 0;
    for (int n = 0; n < 10; n++) begin
      if (ram_writeOn) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) fail_now("strobe_timeout");
    reset  = 1'b1;
    chk_en = 1'b0;
    step();
    chk("mid_rst_writeOn", ram_writeOn, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done_count, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    step();
    chk_en = 1'b1;
    step();

    // Address boundaries, then enough traffic to wrap done_count
    push(5'd31, 1'b1, 32'hFFFFFFFF);
    push(5'd0, 1'b1, 32'h00000001);
    do_read(5'd31, 32'hFFFFFFFF, "rd31");
    do_read(5'd0, 32'h00000001, "rd0");
    wait_idle(40);
    chk("boundary_done", done_count, 4);
    for (int i = 0; i < 252; i++) begin
      if (i % 3 == 0) push(5'($urandom_range(0, 31)), 1'b0, 32'h0);
      else push(5'($urandom_range(0, 31)), 1'b1, $urandom);
    end
    wait_idle(200);
    chk("done_wrap", done_count, 0);
    step();
    chk("model_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
